// File: rtl/shrinking_border.sv
// Animated playfield border: inset grows/shrinks on animation strobes under a static/shrink-once/pulse FSM.
// Latency: edges and o_at_max are combinational from the inset register; o_wall is registered (1 cycle).
// Backpressure: none; the strobe is a single-cycle event that is consumed in the cycle it arrives.
module shrinking_border #(
    parameter int SIZE      = 40,
    parameter int MAX_INSET = 200,
    parameter int STEP      = 1,
    parameter int PERIOD    = 4,
    parameter int DWELL     = 8,
    parameter int THICK     = 4,
    parameter int D_WIDTH   = 640,
    parameter int D_HEIGHT  = 480
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ani_stb,
    input  logic        i_animate,
    input  logic [1:0]  i_mode,
    input  logic        i_restart,
    input  logic [11:0] i_px_x,
    input  logic [11:0] i_px_y,
    output logic [11:0] o_l,
    output logic [11:0] o_r,
    output logic [11:0] o_t,
    output logic [11:0] o_b,
    output logic        o_wall,
    output logic        o_at_max,
    output logic [1:0]  o_state
);
    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [12:0]   SIZE_W     = 13'(SIZE);
    localparam logic [12:0]   MAX_W      = 13'(MAX_INSET);
    localparam logic [12:0]   STEP_W     = 13'(STEP);
    localparam logic [12:0]   THICK_W    = 13'(THICK);
    localparam logic [12:0]   WIDTH_W    = 13'(D_WIDTH);
    localparam logic [12:0]   HEIGHT_W   = 13'(D_HEIGHT);
    localparam logic [CW-1:0] CNT_LAST   = CW'(PERIOD - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHRINK = 2'd1,
        ST_MAX    = 2'd2,
        ST_EXPAND = 2'd3
    } state_t;

    state_t        state, nxt_state;
    logic [11:0]   inset, nxt_inset;
    logic [CW-1:0] cnt, nxt_cnt;
    logic [DW-1:0] dwell, nxt_dwell;
    logic          wall_q;

    logic        qual_stb, step, mode_static, mode_pulse, mode_once;
    logic [12:0] inset_w, sum_w, inc_w, dec_w;
    logic [12:0] l_w, r_w, t_w, b_w, x_w, y_w;
    logic        in_outer, in_inner;

    assign qual_stb    = i_ani_stb & i_animate;
    assign mode_once   = (i_mode == 2'b01);
    assign mode_pulse  = (i_mode == 2'b10);
    assign mode_static = ~(mode_once | mode_pulse);
    assign step        = qual_stb && (state != ST_IDLE) && (cnt == CNT_LAST);

    // 13-bit arithmetic so the saturating add/subtract never wraps
    assign inset_w = {1'b0, inset};
    assign sum_w   = inset_w + STEP_W;
    assign inc_w   = (sum_w >= MAX_W) ? MAX_W : sum_w;
    assign dec_w   = (inset_w < SIZE_W + STEP_W) ? SIZE_W : inset_w - STEP_W;

    always_comb begin
        nxt_state = state;
        nxt_inset = inset;
        nxt_cnt   = cnt;
        nxt_dwell = dwell;

        if (qual_stb && state != ST_IDLE)
            nxt_cnt = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;

        case (state)
            ST_IDLE: begin
                if (i_animate && !mode_static)
                    nxt_state = ST_SHRINK;
            end
            ST_SHRINK: begin
                if (step) begin
                    nxt_inset = inc_w[11:0];
                    if (inc_w == MAX_W) begin
                        nxt_state = ST_MAX;
                        nxt_dwell = '0;
                    end
                end
            end
            ST_MAX: begin
                if (mode_pulse && step) begin
                    if (dwell == DWELL_LAST) begin
                        nxt_state = ST_EXPAND;
                        nxt_dwell = '0;
                    end else begin
                        nxt_dwell = dwell + 1'b1;
                    end
                end
            end
            ST_EXPAND: begin
                if (mode_once) begin
                    nxt_state = ST_SHRINK;
                end else if (step) begin
                    nxt_inset = dec_w[11:0];
                    if (dec_w == SIZE_W)
                        nxt_state = mode_pulse ? ST_SHRINK : ST_IDLE;
                end
            end
            default: nxt_state = ST_IDLE;
        endcase

        // Going static freezes the arena where it is rather than snapping back
        if (mode_static) begin
            nxt_state = ST_IDLE;
            nxt_inset = inset;
        end

        if (nxt_state == ST_IDLE) begin
            nxt_cnt   = '0;
            nxt_dwell = '0;
        end

        if (i_restart) begin
            nxt_state = ST_IDLE;
            nxt_inset = 12'(SIZE);
            nxt_cnt   = '0;
            nxt_dwell = '0;
        end
    end

    assign l_w = inset_w;
    assign t_w = inset_w;
    assign r_w = WIDTH_W - inset_w;
    assign b_w = HEIGHT_W - inset_w;
    assign x_w = {1'b0, i_px_x};
    assign y_w = {1'b0, i_px_y};

    assign in_outer = (x_w >= l_w - THICK_W) && (x_w <= r_w + THICK_W - 13'd1) &&
                      (y_w >= t_w - THICK_W) && (y_w <= b_w + THICK_W - 13'd1);
    assign in_inner = (x_w >= l_w) && (x_w < r_w) && (y_w >= t_w) && (y_w < b_w);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= ST_IDLE;
            inset  <= 12'(SIZE);
            cnt    <= '0;
            dwell  <= '0;
            wall_q <= 1'b0;
        end else begin
            state  <= nxt_state;
            inset  <= nxt_inset;
            cnt    <= nxt_cnt;
            dwell  <= nxt_dwell;
            wall_q <= in_outer & ~in_inner;
        end
    end

    assign o_l      = l_w[11:0];
    assign o_r      = r_w[11:0];
    assign o_t      = t_w[11:0];
    assign o_b      = b_w[11:0];
    assign o_wall   = wall_q;
    assign o_at_max = (inset_w == MAX_W);
    assign o_state  = state;
endmodule

// File: tb/tb_shrinking_border.sv
// Bench for shrinking_border: three parameterisations share one stimulus stream and are
// checked each cycle against a frame/step reference model, plus fixed-value corner sequences.
module tb_shrinking_border;
    localparam int N = 3;
    localparam int P_SIZE = 40, P_PERIOD = 4, P_THICK = 4, P_W = 640, P_H = 480;
    int p_step [N] = '{1, 3, 1};
    int p_max  [N] = '{200, 45, 42};
    int p_dwell[N] = '{8, 2, 2};

    logic        clk = 1'b0;
    logic        rst_n, ani_stb, animate, restart;
    logic [1:0]  mode;
    logic [11:0] px_x, px_y;
    logic [11:0] o_l[N], o_r[N], o_t[N], o_b[N];
    logic        o_wall[N], o_at_max[N];
    logic [1:0]  o_state[N];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shrinking_border #(.STEP(1), .MAX_INSET(200), .DWELL(8)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_ani_stb(ani_stb), .i_animate(animate), .i_mode(mode),
        .i_restart(restart), .i_px_x(px_x), .i_px_y(px_y), .o_l(o_l[0]), .o_r(o_r[0]),
        .o_t(o_t[0]), .o_b(o_b[0]), .o_wall(o_wall[0]), .o_at_max(o_at_max[0]), .o_state(o_state[0]));
    shrinking_border #(.STEP(3), .MAX_INSET(45), .DWELL(2)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_ani_stb(ani_stb), .i_animate(animate), .i_mode(mode),
        .i_restart(restart), .i_px_x(px_x), .i_px_y(px_y), .o_l(o_l[1]), .o_r(o_r[1]),
        .o_t(o_t[1]), .o_b(o_b[1]), .o_wall(o_wall[1]), .o_at_max(o_at_max[1]), .o_state(o_state[1]));
    shrinking_border #(.STEP(1), .MAX_INSET(42), .DWELL(2)) dut_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_ani_stb(ani_stb), .i_animate(animate), .i_mode(mode),
        .i_restart(restart), .i_px_x(px_x), .i_px_y(px_y), .o_l(o_l[2]), .o_r(o_r[2]),
        .o_t(o_t[2]), .o_b(o_b[2]), .o_wall(o_wall[2]), .o_at_max(o_at_max[2]), .o_state(o_state[2]));

    // Reference model: phase 0 idle, 1 growing, 2 held at max, 3 receding
    int m_inset[N], m_phase[N], m_frames[N], m_dwell[N];
    bit m_wall[N];

    function automatic bit wall_ref(int x, int y, int ins);
        int l = ins, r = P_W - ins, t = ins, b = P_H - ins;
        bit outer = (x >= l - P_THICK) && (x <= r + P_THICK - 1) &&
                    (y >= t - P_THICK) && (y <= b + P_THICK - 1);
        bit inner = (x >= l) && (x < r) && (y >= t) && (y < b);
        return outer && !inner;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_inset[k] = P_SIZE; m_phase[k] = 0; m_frames[k] = 0; m_dwell[k] = 0; m_wall[k] = 0;
        end
    endtask

    task automatic model_clock();
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int k = 0; k < N; k++) begin
            int np;
            bit counting, stepping;
            m_wall[k] = wall_ref(int'(px_x), int'(px_y), m_inset[k]);
            if (restart) begin
                m_inset[k] = P_SIZE; m_phase[k] = 0; m_frames[k] = 0; m_dwell[k] = 0;
                continue;
            end
            np = m_phase[k];
            counting = ani_stb && animate && m_phase[k] != 0;
            stepping = counting && (m_frames[k] == P_PERIOD - 1);
            if (counting) m_frames[k] = (m_frames[k] + 1) % P_PERIOD;
            if (mode == 2'd0 || mode == 2'd3) begin
                np = 0;
            end else if (m_phase[k] == 0) begin
                if (animate) np = 1;
            end else if (m_phase[k] == 1) begin
                if (stepping) begin
                    m_inset[k] = (m_inset[k] + p_step[k] > p_max[k]) ? p_max[k] : m_inset[k] + p_step[k];
                    if (m_inset[k] == p_max[k]) begin np = 2; m_dwell[k] = 0; end
                end
            end else if (m_phase[k] == 2) begin
                if (mode == 2'd2 && stepping) begin
                    m_dwell[k]++;
                    if (m_dwell[k] == p_dwell[k]) begin np = 3; m_dwell[k] = 0; end
                end
            end else begin
                if (mode == 2'd1) np = 1;
                else if (stepping) begin
                    m_inset[k] = (m_inset[k] - p_step[k] < P_SIZE) ? P_SIZE : m_inset[k] - p_step[k];
                    if (m_inset[k] == P_SIZE) np = (mode == 2'd2) ? 1 : 0;
                end
            end
            if (np == 0) begin m_frames[k] = 0; m_dwell[k] = 0; end
            m_phase[k] = np;
        end
    endtask

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < N; k++) begin
            chk($sformatf("dut%0d o_l", k), int'(o_l[k]), m_inset[k]);
            chk($sformatf("dut%0d o_r", k), int'(o_r[k]), P_W - m_inset[k]);
            chk($sformatf("dut%0d o_t", k), int'(o_t[k]), m_inset[k]);
            chk($sformatf("dut%0d o_b", k), int'(o_b[k]), P_H - m_inset[k]);
            chk($sformatf("dut%0d o_at_max", k), int'(o_at_max[k]), int'(m_inset[k] == p_max[k]));
            chk($sformatf("dut%0d o_state", k), int'(o_state[k]), m_phase[k]);
            chk($sformatf("dut%0d o_wall", k), int'(o_wall[k]), int'(m_wall[k]));
        end
    endtask

    task automatic cyc();
        model_clock();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic strobes(int n);
        for (int i = 0; i < n; i++) begin
            ani_stb = 1'b1; cyc();
            ani_stb = 1'b0; cyc();
        end
    endtask

    typedef struct { int x; int y; int exp_wall; } wall_vec_t;
    wall_vec_t wv[13];

    typedef struct { int inset; int state; } pulse_vec_t;
    pulse_vec_t pv[6];

    initial begin
        wv[0]  = '{35, 100, 0};  wv[1]  = '{36, 100, 1};  wv[2]  = '{39, 100, 1};
        wv[3]  = '{40, 100, 0};  wv[4]  = '{603, 100, 1}; wv[5]  = '{604, 100, 0};
        wv[6]  = '{300, 38, 1};  wv[7]  = '{300, 35, 0};  wv[8]  = '{300, 443, 1};
        wv[9]  = '{300, 444, 0}; wv[10] = '{2000, 100, 0}; wv[11] = '{599, 439, 0};
        wv[12] = '{600, 439, 1};
        pv[0] = '{41, 1}; pv[1] = '{42, 2}; pv[2] = '{42, 2};
        pv[3] = '{42, 3}; pv[4] = '{41, 3}; pv[5] = '{40, 1};

        rst_n = 1'b0; ani_stb = 1'b0; animate = 1'b0; restart = 1'b0;
        mode = 2'b00; px_x = '0; px_y = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset o_l", int'(o_l[0]), 40);
        chk("reset o_r", int'(o_r[0]), 600);
        chk("reset o_t", int'(o_t[0]), 40);
        chk("reset o_b", int'(o_b[0]), 440);
        chk("reset o_state", int'(o_state[0]), 0);
        chk("reset o_wall", int'(o_wall[0]), 0);
        chk("reset o_at_max", int'(o_at_max[0]), 0);
        compare_all();
        rst_n = 1'b1;
        cyc();

        // Shrink-once: step every 4 qualified strobes, frozen while animate is low
        mode = 2'b01; animate = 1'b1;
        cyc();
        chk("once enters shrink", int'(o_state[0]), 1);
        strobes(4);
        chk("once 4 strobes o_l", int'(o_l[0]), 41);
        chk("once 4 strobes o_r", int'(o_r[0]), 599);
        chk("sat first step", int'(o_l[1]), 43);
        strobes(4);
        chk("once 8 strobes o_l", int'(o_l[0]), 42);
        chk("sat reaches max", int'(o_l[1]), 45);
        chk("sat at_max", int'(o_at_max[1]), 1);
        chk("sat state max", int'(o_state[1]), 2);
        animate = 1'b0;
        strobes(8);
        chk("frozen o_l", int'(o_l[0]), 42);
        animate = 1'b1;
        strobes(80);
        chk("sat holds 45", int'(o_l[1]), 45);
        chk("sat holds state", int'(o_state[1]), 2);
        chk("long run o_l", int'(o_l[0]), 62);

        // Pulse cycle on the small-arena instance
        restart = 1'b1; cyc(); restart = 1'b0;
        chk("restart o_l", int'(o_l[0]), 40);
        mode = 2'b10;
        cyc();
        for (int i = 0; i < 6; i++) begin
            strobes(4);
            chk($sformatf("pulse step%0d inset", i), int'(o_l[2]), pv[i].inset);
            chk($sformatf("pulse step%0d state", i), int'(o_state[2]), pv[i].state);
        end

        // Restart coincident with a step event
        mode = 2'b01;
        restart = 1'b1; cyc(); restart = 1'b0;
        cyc();
        strobes(4);
        chk("pre-restart inset", int'(o_l[1]), 43);
        strobes(3);
        ani_stb = 1'b1; restart = 1'b1; cyc();
        ani_stb = 1'b0; restart = 1'b0;
        chk("restart wins inset", int'(o_l[1]), 40);
        chk("restart wins state", int'(o_state[1]), 0);
        cyc();
        chk("restart reenter shrink", int'(o_state[0]), 1);
        strobes(3);
        chk("counter cleared", int'(o_l[0]), 40);
        strobes(1);
        chk("fresh step", int'(o_l[0]), 41);

        // Asynchronous reset away from any clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("async o_l", int'(o_l[0]), 40);
        chk("async o_r", int'(o_r[0]), 600);
        chk("async o_b", int'(o_b[0]), 440);
        chk("async o_state", int'(o_state[0]), 0);
        chk("async o_wall", int'(o_wall[0]), 0);
        model_reset();
        cyc();
        rst_n = 1'b1; mode = 2'b00;
        cyc();

        // Wall band at inset 40
        for (int i = 0; i < 13; i++) begin
            px_x = 12'(wv[i].x); px_y = 12'(wv[i].y);
            cyc();
            chk($sformatf("wall (%0d,%0d)", wv[i].x, wv[i].y), int'(o_wall[0]), wv[i].exp_wall);
        end

        // Randomised operation against the model
        for (int i = 0; i < 4000; i++) begin
            ani_stb = ($urandom_range(0, 1) == 1);
            animate = ($urandom_range(0, 9) != 0);
            restart = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 59) == 0) mode = 2'($urandom_range(0, 3));
            if (i < 100) mode = 2'b10;
            px_x = 12'($urandom_range(0, 700));
            px_y = 12'($urandom_range(0, 520));
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
